// File: rtl/fetch_issue.sv
// fetch_issue: holds the PC, fetches one instruction at a time from imem and issues it to decode.
// Optional macro FETCH_EXC_EN builds the SIIC/RTI exception-return path and the epc register.
module fetch_issue #(
    parameter int unsigned        PC_W       = 16,
    parameter logic [PC_W-1:0]    RESET_PC   = PC_W'(16'h0000),
    parameter logic [PC_W-1:0]    EXC_VECTOR = PC_W'(16'h0002)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [PC_W-1:0] imem_data,
    input  logic            imem_done,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] pc_inc,
    output logic            instr_valid,
    input  logic            stall_in,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic            halt_o
);
    localparam int unsigned     OPC_W    = 5;
    localparam int unsigned     OPC_LSB  = PC_W - OPC_W;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;
    localparam logic [PC_W-1:0] NOP_WORD = PC_W'(16'h0800);
    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(2);
`ifdef FETCH_EXC_EN
    localparam logic [OPC_W-1:0] OPC_SIIC = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_RTI  = 5'b00011;
`endif

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [OPC_W-1:0]  opcode;

    assign opcode    = instr[PC_W-1:OPC_LSB];
    assign imem_addr = pc;

`ifdef FETCH_EXC_EN
    logic [PC_W-1:0] epc_q;
    assign epc = epc_q;
`else
    assign epc = '0;
`endif

    // Fetch/issue sequencer; redirect outranks every other transition except in HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= NOP_WORD;
            pc_inc      <= '0;
            instr_valid <= 1'b0;
            imem_rd     <= 1'b0;
            halt_o      <= 1'b0;
`ifdef FETCH_EXC_EN
            epc_q       <= '0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_en) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                        if (imem_done) begin
                            state   <= FETCH;
                            imem_rd <= 1'b1;
                        end else begin
                            state   <= DRAIN;
                            imem_rd <= 1'b0;
                        end
                    end else if (imem_done) begin
                        instr       <= imem_data;
                        pc_inc      <= pc + PC_STEP;
                        instr_valid <= 1'b1;
                        imem_rd     <= 1'b0;
                        state       <= ISSUE;
                    end else begin
                        imem_rd <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (redirect_en) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                        imem_rd     <= 1'b1;
                        state       <= FETCH;
                    end else if (!stall_in) begin
                        instr_valid <= 1'b0;
                        if (opcode == OPC_HALT) begin
                            halt_o  <= 1'b1;
                            imem_rd <= 1'b0;
                            state   <= HALTED;
                        end else begin
                            imem_rd <= 1'b1;
                            state   <= FETCH;
`ifdef FETCH_EXC_EN
                            if (opcode == OPC_SIIC) begin
                                epc_q <= pc_inc;
                                pc    <= EXC_VECTOR;
                            end else if (opcode == OPC_RTI) begin
                                pc    <= epc_q;
                            end else begin
                                pc    <= pc_inc;
                            end
`else
                            pc      <= pc_inc;
`endif
                        end
                    end
                end
                DRAIN: begin
                    // A done coinciding with a redirect still retires the discarded fetch.
                    if (redirect_en) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                    end
                    if (imem_done) begin
                        imem_rd <= 1'b1;
                        state   <= FETCH;
                    end
                end
                HALTED: begin
                    imem_rd     <= 1'b0;
                    instr_valid <= 1'b0;
                    halt_o      <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule
